// File: rtl/lif_update_scheduler.sv
// Shares one combinational LIF adder across NUM_NEURONS neurons per timestep.
// Define LIF_SCHED_SPIKE_COUNT_EN to add the per-timestep spike_count output.
module lif_update_scheduler #(
  parameter int NUM_NEURONS   = 30,
  parameter int IDX_W         = 5,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             timestep_start,
  output logic             busy,
  output logic             done,
  output logic             w_req,
  output logic [IDX_W-1:0] w_idx,
  input  logic             w_valid,
  input  logic [31:0]      w_data,
  output logic [IDX_W-1:0] pot_rd_idx,
  input  logic [31:0]      pot_rd_data,
  output logic             pot_wr_en,
  output logic [IDX_W-1:0] pot_wr_idx,
  output logic [31:0]      pot_wr_data,
  output logic             set_adder,
  output logic             clear_adder,
  output logic [31:0]      adder_weight,
  output logic [31:0]      adder_decayed,
  input  logic [31:0]      adder_final,
  input  logic             adder_spike,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx
`ifdef LIF_SCHED_SPIKE_COUNT_EN
  ,
  output logic [IDX_W:0]   spike_count
`endif
);

  typedef enum logic [2:0] {
    S_CONFIG,
    S_IDLE,
    S_FETCH,
    S_SETTLE,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t state, state_n;
  logic [IDX_W-1:0] idx;
  logic [3:0] cnt;
  logic cfg_arm;
  logic busy_q;
  logic [31:0] weight_reg;
  logic [31:0] decayed_reg;
  logic start_ok;
  logic capture;

  assign start_ok = (state == S_IDLE) && timestep_start;
  // cnt!=0 marks the 2nd+ FETCH cycle, when pot_rd_data is valid
  assign capture = (state == S_FETCH) && (cnt != 4'd0) && w_valid;

  always_comb begin
    state_n = state;
    unique case (state)
      S_CONFIG: if (cfg_arm) state_n = S_IDLE;
      S_IDLE:   if (timestep_start) state_n = S_FETCH;
      S_FETCH:  if (capture) state_n = S_SETTLE;
      S_SETTLE: if (cnt == SETTLE_LAST) state_n = S_WRITE;
      S_WRITE:  state_n = (idx == LAST_IDX) ? S_DONE : S_FETCH;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= S_CONFIG;
      idx         <= '0;
      cnt         <= '0;
      cfg_arm     <= 1'b0;
      busy_q      <= 1'b0;
      weight_reg  <= '0;
      decayed_reg <= '0;
    end else begin
      state   <= state_n;
      // first CONFIG cycle arms, second pulses set_adder
      cfg_arm <= (state == S_CONFIG) && !cfg_arm;
      if (start_ok) begin
        idx    <= '0;
        busy_q <= 1'b1;
      end else if (state == S_DONE) begin
        busy_q <= 1'b0;
      end
      if (state == S_WRITE && idx != LAST_IDX)
        idx <= idx + IDX_ONE;
      if (capture) begin
        weight_reg  <= w_data;
        decayed_reg <= pot_rd_data;
      end
      unique case (state)
        S_FETCH:  cnt <= capture ? 4'd0 : 4'd1;
        S_SETTLE: cnt <= cnt + 4'd1;
        default:  cnt <= 4'd0;
      endcase
    end
  end

`ifdef LIF_SCHED_SPIKE_COUNT_EN
  localparam logic [IDX_W:0] CNT_ONE = (IDX_W + 1)'(1);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)
      spike_count <= '0;
    else if (start_ok)
      spike_count <= '0;
    else if (state == S_WRITE && adder_spike)
      spike_count <= spike_count + CNT_ONE;
  end
`endif

  always_comb begin
    busy        = busy_q;
    done        = 1'b0;
    w_req       = 1'b0;
    w_idx       = '0;
    pot_rd_idx  = '0;
    pot_wr_en   = 1'b0;
    pot_wr_idx  = '0;
    pot_wr_data = '0;
    set_adder   = 1'b0;
    clear_adder = 1'b1;
    spike_valid = 1'b0;
    spike_idx   = '0;
    unique case (state)
      S_CONFIG: set_adder = cfg_arm;
      S_FETCH: begin
        w_req      = 1'b1;
        w_idx      = idx;
        pot_rd_idx = idx;
      end
      S_SETTLE: clear_adder = 1'b0;
      S_WRITE: begin
        clear_adder = 1'b0;
        pot_wr_en   = 1'b1;
        pot_wr_idx  = idx;
        pot_wr_data = adder_final;
        spike_valid = adder_spike;
        spike_idx   = adder_spike ? idx : '0;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign adder_weight  = weight_reg;
  assign adder_decayed = decayed_reg;

endmodule

// File: tb/tb_lif_update_scheduler.sv
// Directed bench for lif_update_scheduler with a table-driven adder
// and weight/potential memories modelled in the bench.
module tb_lif_update_scheduler;

  localparam int N = 30;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        timestep_start = 1'b0;
  logic        busy, done, w_req, w_valid;
  logic [4:0]  w_idx, pot_rd_idx, pot_wr_idx, spike_idx;
  logic [31:0] w_data, pot_rd_data, pot_wr_data;
  logic        pot_wr_en, set_adder, clear_adder, spike_valid;
  logic [31:0] adder_weight, adder_decayed, adder_final;
  logic        adder_spike, s_raw;
`ifdef LIF_SCHED_SPIKE_COUNT_EN
  logic [5:0]  spike_count;
`endif

  lif_update_scheduler dut (
    .CLK(CLK), .RESETn(RESETn), .timestep_start(timestep_start),
    .busy(busy), .done(done), .w_req(w_req), .w_idx(w_idx),
    .w_valid(w_valid), .w_data(w_data), .pot_rd_idx(pot_rd_idx),
    .pot_rd_data(pot_rd_data), .pot_wr_en(pot_wr_en),
    .pot_wr_idx(pot_wr_idx), .pot_wr_data(pot_wr_data),
    .set_adder(set_adder), .clear_adder(clear_adder),
    .adder_weight(adder_weight), .adder_decayed(adder_decayed),
    .adder_final(adder_final), .adder_spike(adder_spike),
    .spike_valid(spike_valid), .spike_idx(spike_idx)
`ifdef LIF_SCHED_SPIKE_COUNT_EN
    , .spike_count(spike_count)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] wmem [32];
  logic [31:0] pmem [32];
  int dly [32];
  int wcnt = 0;
  int cyc = 0;

  // hand-computed LIF results for two vectors; arbitrary but fixed rule otherwise
  function automatic logic [32:0] add_model(input logic [31:0] w,
                                            input logic [31:0] d);
    if (w == 32'h41200000 && d == 32'h42000000) return {1'b1, 32'h40000000};
    if (w == 32'h3F800000 && d == 32'h40000000) return {1'b0, 32'h40400000};
    return {w[0], w + d};
  endfunction

  function automatic int flen_exp(input int i);
    return (dly[i] + 1 > 2) ? dly[i] + 1 : 2;
  endfunction

  assign {s_raw, adder_final} = add_model(adder_weight, adder_decayed);
  assign adder_spike = s_raw & ~clear_adder;
  assign w_valid = w_req && (wcnt >= dly[w_idx]);
  assign w_data = w_valid ? wmem[w_idx] : 32'hDEADBEEF;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    wcnt <= w_req ? wcnt + 1 : 0;
    pot_rd_data <= pmem[pot_rd_idx];
  end

  int nexp = 0, nwr = 0, spikes = 0, flen = 0;
  logic wr_allowed = 1'b1;
  logic [31:0] wr_log [32];
  logic spk_log [32];

  initial begin : monitor
    logic prev_req;
    logic [4:0] prev_idx;
    logic [31:0] prev_aw, prev_ad;
    logic [32:0] m;
    int ni;
    prev_req = 1'b0;
    prev_idx = '0;
    prev_aw = '0;
    prev_ad = '0;
    forever begin
      @(negedge CLK);
      ni = nexp % 32;
      if (pot_wr_en) begin
        m = add_model(wmem[ni], pmem[ni]);
        check("wr_allowed", 32'(wr_allowed), 32'd1);
        check("wr_idx", 32'(pot_wr_idx), 32'(nexp));
        check("wr_data", pot_wr_data, m[31:0]);
        check("spk_valid", 32'(spike_valid), 32'(m[32]));
        if (spike_valid) check("spk_idx", 32'(spike_idx), 32'(nexp));
        wr_log[ni] = pot_wr_data;
        spk_log[ni] = spike_valid;
        if (m[32]) spikes++;
        nexp++;
        nwr++;
      end else if (spike_valid) begin
        check("spk_no_wr", 32'(spike_valid), 32'd0);
      end
      if (w_req) begin
        check("rd_idx", 32'(pot_rd_idx), 32'(w_idx));
        if (prev_req) begin
          check("w_idx_hold", 32'(w_idx), 32'(prev_idx));
          check("aw_hold", adder_weight, prev_aw);
          check("ad_hold", adder_decayed, prev_ad);
        end
        flen++;
      end else if (prev_req) begin
        check("fetch_len", 32'(flen), 32'(flen_exp(prev_idx)));
        flen = 0;
      end
      prev_req = w_req;
      prev_idx = w_idx;
      prev_aw = adder_weight;
      prev_ad = adder_decayed;
    end
  end

  task automatic check_config();
    int n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (set_adder) n++;
    end
    check("set_adder_pulses", 32'(n), 32'd1);
    check("idle_clear", 32'(clear_adder), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_wreq", 32'(w_req), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  task automatic run_ts(input int exp_len);
    int t0;
    int k;
    nexp = 0;
    nwr = 0;
    spikes = 0;
    @(negedge CLK);
    timestep_start = 1'b1;
    @(negedge CLK);
    timestep_start = 1'b0;
    t0 = cyc;
    check("busy_start", 32'(busy), 32'd1);
    k = 0;
    while (!done && k < 1000) begin
      @(negedge CLK);
      timestep_start = (cyc - t0 == 40);
      k++;
    end
    timestep_start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("done_latency", 32'(cyc - t0), 32'(exp_len));
    check("busy_at_done", 32'(busy), 32'd1);
    timestep_start = 1'b1;
    @(negedge CLK);
    timestep_start = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("writes", 32'(nwr), 32'(N));
    check("spikes", 32'(spikes), 32'd15);
`ifdef LIF_SCHED_SPIKE_COUNT_EN
    check("spike_count", 32'(spike_count), 32'd15);
`endif
    repeat (3) @(negedge CLK);
    check("start_at_done_ignored", 32'(busy), 32'd0);
  endtask

  initial begin : stim
    int k;
    for (int i = 0; i < 32; i++) begin
      wmem[i] = 32'(i + 1);
      pmem[i] = 32'(i) << 8;
      dly[i] = 0;
    end
    wmem[0] = 32'h41200000;
    pmem[0] = 32'h42000000;
    wmem[3] = 32'h3F800000;
    pmem[3] = 32'h40000000;

    repeat (2) @(negedge CLK);
    check("rst_clear", 32'(clear_adder), 32'd1);
    check("rst_set", 32'(set_adder), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr", 32'(pot_wr_en), 32'd0);
    check("rst_aw", adder_weight, 32'd0);
    RESETn = 1'b1;
    check_config();

    run_ts(150);
    check("n0_data", wr_log[0], 32'h40000000);
    check("n0_spike", 32'(spk_log[0]), 32'd1);
    check("n3_data", wr_log[3], 32'h40400000);
    check("n3_spike", 32'(spk_log[3]), 32'd0);

    dly[12] = 7;
    run_ts(156);

    nexp = 0;
    nwr = 0;
    @(negedge CLK);
    timestep_start = 1'b1;
    @(negedge CLK);
    timestep_start = 1'b0;
    k = 0;
    while (!(w_req && w_idx == 5) && k < 200) begin
      @(negedge CLK);
      k++;
    end
    while (w_req && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("reach_settle5", 32'(k < 200), 32'd1);
    check("settle_clear", 32'(clear_adder), 32'd0);
    wr_allowed = 1'b0;
    RESETn = 1'b0;
    #1;
    check("abort_wr", 32'(pot_wr_en), 32'd0);
    check("abort_spk", 32'(spike_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_clear", 32'(clear_adder), 32'd1);
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    check_config();
    check("abort_writes", 32'(nwr), 32'd5);
`ifdef LIF_SCHED_SPIKE_COUNT_EN
    check("abort_spike_count", 32'(spike_count), 32'd0);
`endif
    wr_allowed = 1'b1;
    run_ts(156);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lif_update_scheduler.md
Name: lif_update_scheduler

Overview:
- Time-multiplexes one shared combinational LIF potential adder across NUM_NEURONS neurons, one neuron at a time, once per timestep.
- Per neuron: fetches the input weight over a valid handshake, reads the decayed potential from potential memory, and lets the shared adder settle.
- Then writes the final potential back and emits that neuron's spike.
- Sits between the timestep clock generator, the weight/potential memories and the adder's set/clear/data pins.

Parameters:
- NUM_NEURONS, 30, neurons updated per timestep.
- IDX_W, 5, neuron index width; must satisfy 2^IDX_W >= NUM_NEURONS.
- SETTLE_CYCLES, 2, cycles the adder inputs are held stable before its outputs are sampled; legal range 1..15.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- timestep_start  in  1  one-cycle pulse that starts a timestep.
- busy  out  1  high from acceptance of timestep_start until done.
- done  out  1  one-cycle pulse when the last neuron has been written.
- w_req  out  1  weight request.
- w_idx  out  IDX_W  neuron index for the weight request.
- w_valid  in  1  weight valid.
- w_data  in  32  input weight, IEEE-754 single.
- pot_rd_idx  out  IDX_W  potential memory read address; read latency is 1 cycle.
- pot_rd_data  in  32  decayed potential, IEEE-754 single.
- pot_wr_en  out  1  potential write strobe.
- pot_wr_idx  out  IDX_W  potential write address.
- pot_wr_data  out  32  potential write data.
- set_adder  out  1  adder configuration strobe (loads threshold and model).
- clear_adder  out  1  forces the adder spike output low.
- adder_weight  out  32  adder weight operand.
- adder_decayed  out  32  adder decayed-potential operand.
- adder_final  in  32  adder final potential.
- adder_spike  in  1  adder spike.
- spike_valid  out  1  one-cycle strobe; high in WRITE when adder_spike=1.
- spike_idx  out  IDX_W  index of the spiking neuron.

Behaviour:
- Reset: all outputs 0, except clear_adder=1. State=CONFIG, idx=0, operand registers=0.
- FSM states: CONFIG, IDLE, FETCH, SETTLE, WRITE, DONE.
- CONFIG: set_adder=1 for exactly one cycle, then IDLE. CONFIG is entered only after reset.
- IDLE: clear_adder=1, busy=0. On timestep_start=1: idx<=0, busy<=1, go to FETCH.
- FETCH:
  - w_req=1, w_idx=idx, pot_rd_idx=idx, held stable for the whole state; clear_adder=1.
  - w_valid is sampled from the 2nd FETCH cycle onward, so pot_rd_data is already valid.
  - On the first sampled w_valid=1: weight_reg<=w_data, decayed_reg<=pot_rd_data, w_req drops next cycle, go to SETTLE with the settle counter cleared.
  - A w_valid seen in the 1st FETCH cycle is ignored; the source must hold it.
  - No timeout: FETCH waits indefinitely.
- SETTLE:
  - clear_adder=0; adder_weight=weight_reg and adder_decayed=decayed_reg, both driven from registers only.
  - Count SETTLE_CYCLES cycles, then go to WRITE.
- WRITE (one cycle):
  - clear_adder=0; pot_wr_en=1, pot_wr_idx=idx, pot_wr_data=adder_final.
  - spike_valid=adder_spike, spike_idx=idx.
  - If idx==NUM_NEURONS-1 go to DONE; else idx<=idx+1 and go to FETCH.
- DONE: done=1 for one cycle, busy<=0, clear_adder=1, go to IDLE.
- Latency: with zero-wait weights, per neuron = 2 (FETCH) + SETTLE_CYCLES + 1 (WRITE). With defaults, done asserts 150 cycles after the start pulse is accepted.
- Exactly one write per neuron per timestep; indices are ascending; idx never exceeds NUM_NEURONS-1 (no wrap).
- timestep_start while busy=1, including in the same cycle as done: ignored, no queueing.
- Adder operands are held at their last values outside SETTLE/WRITE.
- Asynchronous reset mid-timestep: immediate abort, no pot_wr_en and no spike_valid. The partial timestep is lost, and CONFIG is re-run.

Optional Feature:
- Macro: LIF_SCHED_SPIKE_COUNT_EN.
- When defined:
  - Adds output spike_count [IDX_W:0], which increments on every spike_valid.
  - It is cleared on timestep_start acceptance and on reset.
  - It holds its value after done until the next accepted timestep_start.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then release -> set_adder high exactly 1 cycle, then IDLE with clear_adder=1, busy=0, all other outputs 0.
- Neuron 0: w_data=0x41200000 (10.0), pot_rd_data=0x42000000 (32.0), threshold 40.0 -> pot_wr_data=0x40000000 (2.0), spike_valid=1, spike_idx=0.
- Neuron 3: w_data=0x3F800000 (1.0), pot_rd_data=0x40000000 (2.0) -> pot_wr_data=0x40400000 (3.0), spike_valid=0.
- Full timestep, zero-wait weights, defaults -> 30 writes to idx 0..29 in order; done exactly 150 cycles after start; busy falls with done. A second start pulse mid-run is ignored.
- w_valid delayed 7 cycles on neuron 12 -> w_req, w_idx and pot_rd_idx stay stable throughout; adder operands unchanged until capture; no write for neuron 12 before capture.
- RESETn asserted during SETTLE of neuron 5 -> no write/spike for neuron 5; CONFIG re-runs; the next timestep starts at idx 0. With LIF_SCHED_SPIKE_COUNT_EN defined, spike_count reads 0.
